// File: rtl/cell_0.sv
// cell_0: one tile of a combined multiplier/divider array.
// Selects the addend and carry-in by mode, runs a full adder against the
// incoming partial bit, and registers both sum and carry. Because both
// outputs come from flops, neighbouring tiles can be wired together
// without forming combinational loops.
module cell_0 (
  input  logic CLK,
  input  logic RST,
  input  logic Y_ROW,
  input  logic X_IN,
  input  logic P,
  input  logic IN_PREV,
  input  logic MUL_BAR,
  input  logic C_CP_R,
  input  logic C_CP_RP,
  output logic C_OUT,
  output logic OUT
);

  logic w_a;
  logic w_cin;
  logic w_sum;
  logic w_carry;
  logic r_out;
  logic r_c_out;

  // Mode mux: multiply uses the partial product X&Y with the carry from the
  // previous row; divide uses the conditionally inverted divisor bit with the
  // carry rippling in from the row neighbour.
  always_comb begin
    w_a   = 1'b0;
    w_cin = 1'b0;
    if (MUL_BAR) begin
      w_a   = Y_ROW ^ P;
      w_cin = C_CP_R;
    end else begin
      w_a   = X_IN & Y_ROW;
      w_cin = C_CP_RP;
    end
  end

  // Full adder on the incoming partial bit, selected operand and carry-in.
  always_comb begin
    w_sum   = IN_PREV ^ w_a ^ w_cin;
    w_carry = (IN_PREV & w_a) | (IN_PREV & w_cin) | (w_a & w_cin);
  end

  // Output registers; reset clears them at once and drops any pending result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out   <= 1'b0;
      r_c_out <= 1'b0;
    end else begin
      r_out   <= w_sum;
      r_c_out <= w_carry;
    end
  end

  assign OUT   = r_out;
  assign C_OUT = r_c_out;

endmodule

// File: tb/tb_cell_0.sv
// Scoreboard bench for cell_0: stimulus pushes the expected registered
// result when it drives a vector; a monitor pops and compares one cycle later.
module tb_cell_0;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Y_ROW = 1'b0;
  logic X_IN = 1'b0;
  logic P = 1'b0;
  logic IN_PREV = 1'b0;
  logic MUL_BAR = 1'b0;
  logic C_CP_R = 1'b0;
  logic C_CP_RP = 1'b0;
  logic C_OUT;
  logic OUT;

  typedef struct {
    logic  o;
    logic  c;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cell_0 dut (
    .CLK     (CLK),
    .RST     (RST),
    .Y_ROW   (Y_ROW),
    .X_IN    (X_IN),
    .P       (P),
    .IN_PREV (IN_PREV),
    .MUL_BAR (MUL_BAR),
    .C_CP_R  (C_CP_R),
    .C_CP_RP (C_CP_RP),
    .C_OUT   (C_OUT),
    .OUT     (OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act_o, input logic act_c,
                       input logic exp_o, input logic exp_c);
    n_cmp++;
    if ({act_o, act_c} !== {exp_o, exp_c}) begin
      n_err++;
      $display("FAIL %s: got OUT=%b C_OUT=%b, expected OUT=%b C_OUT=%b",
               name, act_o, act_c, exp_o, exp_c);
    end
  endtask

  task automatic set_inputs(input logic mb, input logic y, input logic x, input logic p,
                            input logic ip, input logic ccr, input logic ccrp);
    MUL_BAR = mb; Y_ROW = y; X_IN = x; P = p;
    IN_PREV = ip; C_CP_R = ccr; C_CP_RP = ccrp;
  endtask

  // Drive a vector at the falling edge and record what the next rising edge must load.
  task automatic drive(input string name, input logic mb, input logic y, input logic x,
                       input logic p, input logic ip, input logic ccr, input logic ccrp,
                       input logic eo, input logic ec);
    exp_t e;
    @(negedge CLK);
    set_inputs(mb, y, x, p, ip, ccr, ccrp);
    e.o = eo; e.c = ec; e.name = name;
    q.push_back(e);
  endtask

  // Reference: arithmetic sum of the three adder inputs.
  function automatic logic [1:0] model(input logic mb, input logic y, input logic x,
                                       input logic p, input logic ip, input logic ccr,
                                       input logic ccrp);
    logic a;
    logic cin;
    a   = mb ? (p ? ~y : y) : (x ? y : 1'b0);
    cin = mb ? ccr : ccrp;
    return 2'(ip) + 2'(a) + 2'(cin);
  endfunction

  // Monitor: one registered result per rising edge, checked just after it.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, OUT, C_OUT, e.o, e.c);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] r;
    logic [6:0] v;

    // Reset held with inputs that would otherwise produce OUT=1.
    set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_initial", OUT, C_OUT, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    check("reset_held_edges", OUT, C_OUT, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    // Directed vectors: mb, y, x, p, ip, ccr, ccrp -> out, c_out
    drive("mul_1x1",            1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("mul_1x1_prev1",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("mul_x0_prev1_cin1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive("div_sub_y1",         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("div_add_y1_cin1",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive("div_sub_y0_all1",    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive("mul_ignores_ccr_p",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("div_ignores_x_ccrp", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("mul_full_3",         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Mid-operation reset: assert between edges, expect immediate clear.
    drive("pre_reset_out1",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("reset_async_clear", OUT, C_OUT, 1'b0, 1'b0);
    set_inputs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #2;
    check("reset_discards_pending", OUT, C_OUT, 1'b0, 1'b0);
    begin
      exp_t e;
      @(negedge CLK);
      set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      e.o = 1'b1; e.c = 1'b0; e.name = "post_reset_first_edge";
      q.push_back(e);
    end

    // Exhaustive sweep across both modes.
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      r = model(v[6], v[5], v[4], v[3], v[2], v[1], v[0]);
      drive($sformatf("sweep_%0d", i), v[6], v[5], v[4], v[3], v[2], v[1], v[0], r[0], r[1]);
    end

    repeat (2) @(posedge CLK);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
